// File: rtl/instr_stream_encoder_if.sv
// Request, instruction-memory and status bundle for instr_stream_encoder.
// The slave view belongs to the encoder; the master view belongs to its driver.
interface instr_stream_encoder_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        op_kind;
  logic              alu_mode;
  logic              set_flags;
  logic [2:0]        alu_func;
  logic [2:0]        rd;
  logic [2:0]        rs1;
  logic [2:0]        rs2;
  logic [3:0]        cond;
  logic [15:0]       imm;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              busy;
  logic              done;
  logic              err;
  logic              overflow;
  logic              verify_err;

  modport slave (
    input  start, in_valid, op_kind, alu_mode,
    input  set_flags, alu_func, rd, rs1, rs2,
    input  cond, imm, mem_rdata,
    output in_ready, mem_we, mem_addr, mem_wdata,
    output busy, done, err, overflow, verify_err
  );

  modport master (
    output start, in_valid, op_kind, alu_mode,
    output set_flags, alu_func, rd, rs1, rs2,
    output cond, imm, mem_rdata,
    input  in_ready, mem_we, mem_addr, mem_wdata,
    input  busy, done, err, overflow, verify_err
  );
endinterface

// File: rtl/instr_stream_encoder.sv
// Packs field-level requests into 32-bit instruction words and writes them out.
// Define INSTR_ENC_READBACK_EN to read each word back and flag mismatches.
module instr_stream_encoder #(
  parameter int ADDR_W    = 8,
  parameter int DEPTH     = 256,
  parameter int BASE_ADDR = 0
) (
  input logic                    clk,
  input logic                    rst_n,
  instr_stream_encoder_if.slave  bus
);

  localparam logic [2:0] OP_ALU_REG = 3'd0;
  localparam logic [2:0] OP_ALU_IMM = 3'd1;
  localparam logic [2:0] OP_LOAD    = 3'd2;
  localparam logic [2:0] OP_STORE   = 3'd3;
  localparam logic [2:0] OP_BRANCH  = 3'd4;
  localparam logic [2:0] OP_NOP     = 3'd5;
  localparam logic [2:0] OP_HALT    = 3'd6;

  localparam logic [31:0] W_NOP  = 32'hC800_0000;
  localparam logic [31:0] W_HALT = 32'hD000_0000;

  localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST  =
    ADDR_W'(BASE_ADDR + DEPTH - 1);

`ifdef INSTR_ENC_READBACK_EN
  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_RDBK, S_CHECK, S_DONE
  } state_e;
`else
  typedef enum logic [1:0] {
    S_IDLE, S_WRITE, S_DONE
  } state_e;
`endif

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              ovf_q, ovf_d;
  logic              verr_q, verr_d;
  logic [31:0]       enc_word;
  logic              enc_ok;
  logic              accept;
  logic              exit_now;

  always_comb begin
    enc_word = '0;
    enc_ok   = 1'b1;
    unique case (1'b1)
      bus.op_kind == OP_ALU_REG: begin
        // a zero opcode field would decode as the immediate form
        enc_ok   = |{bus.set_flags, bus.alu_func[2:1]};
        enc_word = {2'b01, bus.alu_mode, bus.set_flags,
                    bus.alu_func, bus.rd, bus.rs1,
                    bus.rs2, 16'h0000};
      end
      bus.op_kind == OP_ALU_IMM:
        enc_word = {2'b00, bus.alu_mode, bus.set_flags,
                    2'b00, 1'b0, bus.rd, bus.rs1,
                    3'b000, bus.imm};
      bus.op_kind == OP_LOAD:
        enc_word = {2'b10, 1'b0, 3'b000, 1'b0, bus.rd,
                    bus.rs1, 3'b000, bus.imm};
      bus.op_kind == OP_STORE:
        enc_word = {2'b10, 1'b0, 3'b000, 1'b1, 3'b000,
                    bus.rs1, bus.rs2, bus.imm};
      bus.op_kind == OP_BRANCH:
        enc_word = {2'b11, 1'b0, 2'b00,
                    bus.cond != 4'hE, 1'b0, bus.cond,
                    5'b00000, bus.imm};
      bus.op_kind == OP_NOP:  enc_word = W_NOP;
      bus.op_kind == OP_HALT: enc_word = W_HALT;
      default:                enc_ok   = 1'b0;
    endcase
  end

  assign accept = bus.in_valid && (state_q == S_IDLE);

`ifdef INSTR_ENC_READBACK_EN
  assign exit_now = (state_q == S_CHECK);
`else
  assign exit_now = (state_q == S_WRITE);
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    done_d  = done_q;
    ovf_d   = ovf_q;
    verr_d  = verr_q;
    err_d   = 1'b0;
    if (bus.start) begin
      state_d = S_IDLE;
      addr_d  = FIRST;
      done_d  = 1'b0;
      ovf_d   = 1'b0;
      verr_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept && enc_ok) begin
            wdata_d = enc_word;
            state_d = S_WRITE;
          end else if (accept) begin
            err_d = 1'b1;
          end
        end
`ifdef INSTR_ENC_READBACK_EN
        S_WRITE: state_d = S_RDBK;
        S_RDBK:  state_d = S_CHECK;
        S_CHECK: begin
          if (bus.mem_rdata != wdata_q) verr_d = 1'b1;
        end
`else
        S_WRITE: ;
`endif
        default: ;
      endcase
      if (exit_now) begin
        if (wdata_q == W_HALT) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else if (addr_q == LAST) begin
          ovf_d   = 1'b1;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = S_IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_DONE;
      addr_q  <= FIRST;
      wdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
      verr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
      verr_q  <= verr_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.mem_we    = (state_q == S_WRITE);
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.busy      = (state_q != S_IDLE) &&
                         (state_q != S_DONE);
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.overflow  = ovf_q;

`ifdef INSTR_ENC_READBACK_EN
  assign bus.verify_err = verr_q;
`else
  logic unused_rdbk;
  assign unused_rdbk    = ^{bus.mem_rdata, verr_q, verr_d};
  assign bus.verify_err = 1'b0;
`endif

endmodule
